// File: rtl/dds_phase_accum.sv
// dds_phase_accum: prescaled DDS phase accumulator with offset, wrap flag and wrap-synchronised FTW loading
module dds_phase_accum #(
  parameter int ACC_W    = 32,
  parameter int PRESCALE = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RUN,
  input  logic [ACC_W-1:0] FTW_IN,
  input  logic             FTW_SYNC,
  input  logic             FTW_VALID,
  output logic             FTW_READY,
  input  logic [ACC_W-1:0] PHASE_OFS,
  input  logic             PHASE_CLR,
  output logic [ACC_W-1:0] DDS,
  output logic             DDS_VALID,
  output logic             WRAP
);
  localparam int PC_W = $clog2(PRESCALE) + 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PEND} state_t;
  state_t           state;
  logic [ACC_W-1:0] acc, acc_n, ftw_active, ftw_pend;
  logic [PC_W-1:0]  pc;
  logic             carry, tick, accept;
  assign tick = RUN && pc == PC_W'(PRESCALE - 1);
  assign {carry, acc_n} = {1'b0, acc} + {1'b0, ftw_active};
  assign FTW_READY = state != S_PEND;
  assign accept = FTW_VALID && FTW_READY;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc        <= '0;
      ftw_active <= '0;
      ftw_pend   <= '0;
      pc         <= '0;
      DDS        <= '0;
      DDS_VALID  <= 1'b0;
      WRAP       <= 1'b0;
      state      <= S_IDLE;
    end else begin
      if (accept && !FTW_SYNC) ftw_active <= FTW_IN;
      if (accept && FTW_SYNC) ftw_pend <= FTW_IN;
      if (PHASE_CLR) begin
        acc       <= '0;
        pc        <= '0;
        DDS       <= PHASE_OFS;
        DDS_VALID <= 1'b0;
        WRAP      <= 1'b0;
      end else begin
        DDS_VALID <= tick;
        WRAP      <= tick && carry;
        if (tick) begin
          pc  <= '0;
          acc <= acc_n;
          DDS <= acc_n + PHASE_OFS;
        end else if (RUN) pc <= pc + 1'b1;
      end
      // the carrying tick still used the old word; the pending one takes over afterwards
      if (state == S_PEND) begin
        if (!PHASE_CLR && tick && carry) begin
          ftw_active <= ftw_pend;
          state      <= RUN ? S_RUN : S_IDLE;
        end
      end else state <= (accept && FTW_SYNC) ? S_PEND : RUN ? S_RUN : S_IDLE;
    end
  end
endmodule

// File: tb/tb_dds_phase_accum.sv
// tb_dds_phase_accum: directed self-checking bench, PRESCALE=1 and PRESCALE=4 instances on shared stimulus
module tb_dds_phase_accum;
  logic        clk = 1'b0;
  logic        rst, run, ftw_sync, ftw_valid, phase_clr;
  logic [31:0] ftw_in, phase_ofs;
  logic        rdy1, val1, wrap1, rdy4, val4, wrap4;
  logic [31:0] dds1, dds4;
  int          checks = 0;
  int          failures = 0;
  always #5 clk = ~clk;
  dds_phase_accum #(.ACC_W(32), .PRESCALE(1)) dut1 (
    .CLK(clk), .RESET(rst), .RUN(run), .FTW_IN(ftw_in), .FTW_SYNC(ftw_sync),
    .FTW_VALID(ftw_valid), .FTW_READY(rdy1), .PHASE_OFS(phase_ofs), .PHASE_CLR(phase_clr),
    .DDS(dds1), .DDS_VALID(val1), .WRAP(wrap1));
  dds_phase_accum #(.ACC_W(32), .PRESCALE(4)) dut4 (
    .CLK(clk), .RESET(rst), .RUN(run), .FTW_IN(ftw_in), .FTW_SYNC(ftw_sync),
    .FTW_VALID(ftw_valid), .FTW_READY(rdy4), .PHASE_OFS(phase_ofs), .PHASE_CLR(phase_clr),
    .DDS(dds4), .DDS_VALID(val4), .WRAP(wrap4));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    {rst, run, ftw_sync, ftw_valid, phase_clr, ftw_in, phase_ofs} = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic load_now(input logic [31:0] w);
    run = 1'b0; ftw_valid = 1'b1; ftw_sync = 1'b0; ftw_in = w;
    step();
    ftw_valid = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({rdy1, val1, wrap1, dds1} !== {3'b100, 32'h0}) begin
      failures++; $display("FAIL reset1 got=%h exp=%h", {rdy1, val1, wrap1, dds1}, {3'b100, 32'h0});
    end
    checks++;
    if ({rdy4, val4, wrap4, dds4} !== {3'b100, 32'h0}) begin
      failures++; $display("FAIL reset4 got=%h exp=%h", {rdy4, val4, wrap4, dds4}, {3'b100, 32'h0});
    end
  endtask
  task automatic test_basic();
    logic [33:0] exp [4] = '{{2'b10, 32'h40000000}, {2'b10, 32'h80000000},
                             {2'b10, 32'hC0000000}, {2'b11, 32'h00000000}};
    do_reset();
    load_now(32'h40000000);
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({val1, wrap1, dds1} !== exp[i]) begin
        failures++; $display("FAIL basic[%0d] got=%h exp=%h", i, {val1, wrap1, dds1}, exp[i]);
      end
    end
  endtask
  task automatic test_prescale();
    logic [32:0] e;
    do_reset();
    load_now(32'h10000000);
    run = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      e = {i % 4 == 0, 32'(i / 4) * 32'h10000000};
      checks++;
      if ({val4, dds4} !== e) begin
        failures++; $display("FAIL prescale[%0d] got=%h exp=%h", i, {val4, dds4}, e);
      end
    end
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({val4, dds4} !== {1'b0, 32'h20000000}) begin
        failures++; $display("FAIL hold[%0d] got=%h exp=%h", i, {val4, dds4}, {1'b0, 32'h20000000});
      end
    end
    run = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      e = (i == 2) ? {1'b1, 32'h30000000} : (i == 6) ? {1'b1, 32'h40000000} :
          {1'b0, (i < 2) ? 32'h20000000 : 32'h30000000};
      checks++;
      if ({val4, dds4} !== e) begin
        failures++; $display("FAIL resume[%0d] got=%h exp=%h", i, {val4, dds4}, e);
      end
    end
  endtask
  task automatic test_sync_load();
    logic [34:0] exp [5] = '{{3'b010, 32'h80000000}, {3'b010, 32'hC0000000},
                             {3'b111, 32'h00000000}, {3'b110, 32'h20000000},
                             {3'b110, 32'h40000000}};
    do_reset();
    load_now(32'h40000000);
    run = 1'b1;
    step();
    ftw_valid = 1'b1; ftw_sync = 1'b1; ftw_in = 32'h20000000;
    for (int i = 0; i < 5; i++) begin
      step();
      // a second immediate word is held throughout PEND; it only lands once ready returns
      if (i == 0) begin ftw_sync = 1'b0; ftw_in = 32'h20000000; end
      if (i == 3) ftw_valid = 1'b0;
      checks++;
      if ({rdy1, val1, wrap1, dds1} !== exp[i]) begin
        failures++; $display("FAIL sync[%0d] got=%h exp=%h", i, {rdy1, val1, wrap1, dds1}, exp[i]);
      end
    end
  endtask
  task automatic test_offset();
    logic [33:0] exp [4] = '{{2'b10, 32'hC0000000}, {2'b10, 32'h00000000},
                             {2'b10, 32'h40000000}, {2'b11, 32'h80000000}};
    do_reset();
    phase_ofs = 32'h80000000;
    load_now(32'h40000000);
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({val1, wrap1, dds1} !== exp[i]) begin
        failures++; $display("FAIL offset[%0d] got=%h exp=%h", i, {val1, wrap1, dds1}, exp[i]);
      end
    end
  endtask
  task automatic test_clear_and_reset();
    logic [33:0] exp [5] = '{{2'b10, 32'h40000000}, {2'b10, 32'h80000000},
                             {2'b10, 32'hC0000000}, {2'b11, 32'h00000000},
                             {2'b10, 32'h40000000}};
    do_reset();
    phase_ofs = 32'h11110000;
    load_now(32'h40000000);
    run = 1'b1;
    step();
    step();
    phase_clr = 1'b1;
    step();
    phase_clr = 1'b0;
    checks++;
    if ({val1, wrap1, dds1} !== {2'b00, 32'h11110000}) begin
      failures++; $display("FAIL clr got=%h exp=%h", {val1, wrap1, dds1}, {2'b00, 32'h11110000});
    end
    step();
    checks++;
    if ({val1, wrap1, dds1} !== {2'b10, 32'h51110000}) begin
      failures++; $display("FAIL clr_next got=%h exp=%h", {val1, wrap1, dds1}, {2'b10, 32'h51110000});
    end
    ftw_valid = 1'b1; ftw_sync = 1'b1; ftw_in = 32'h01000000;
    step();
    ftw_valid = 1'b0;
    checks++;
    if (rdy1 !== 1'b0) begin
      failures++; $display("FAIL pend_ready got=%b exp=0", rdy1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({rdy1, val1, wrap1, dds1} !== {3'b100, 32'h0}) begin
      failures++; $display("FAIL pend_reset got=%h exp=%h", {rdy1, val1, wrap1, dds1}, {3'b100, 32'h0});
    end
    phase_ofs = 32'h0;
    load_now(32'h40000000);
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({val1, wrap1, dds1} !== exp[i]) begin
        failures++; $display("FAIL post_reset[%0d] got=%h exp=%h", i, {val1, wrap1, dds1}, exp[i]);
      end
    end
  endtask
  task automatic test_back_to_back();
    do_reset();
    load_now(32'h40000000);
    run = 1'b1;
    step();
    ftw_valid = 1'b1; ftw_sync = 1'b0; ftw_in = 32'h01000000;
    step();
    ftw_valid = 1'b0;
    checks++;
    if (dds1 !== 32'h80000000) begin
      failures++; $display("FAIL b2b_old got=%h exp=80000000", dds1);
    end
    step();
    checks++;
    if (dds1 !== 32'h81000000) begin
      failures++; $display("FAIL b2b_new got=%h exp=81000000", dds1);
    end
  endtask
  task automatic test_ftw_edges();
    logic [33:0] exp [3] = '{{2'b10, 32'hFFFFFFFF}, {2'b11, 32'hFFFFFFFE}, {2'b11, 32'hFFFFFFFD}};
    do_reset();
    phase_ofs = 32'h12345678;
    run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({val1, wrap1, dds1} !== {2'b10, 32'h12345678}) begin
        failures++; $display("FAIL zero_ftw[%0d] got=%h exp=%h", i, {val1, wrap1, dds1}, {2'b10, 32'h12345678});
      end
    end
    do_reset();
    load_now(32'hFFFFFFFF);
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({val1, wrap1, dds1} !== exp[i]) begin
        failures++; $display("FAIL ones[%0d] got=%h exp=%h", i, {val1, wrap1, dds1}, exp[i]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_prescale();
    test_sync_load();
    test_offset();
    test_clear_and_reset();
    test_back_to_back();
    test_ftw_edges();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dds_phase_accum.md
Name: dds_phase_accum

Overview:
Numerically controlled phase accumulator. It sits directly upstream of the sine lookup stage and drives that stage's 32-bit DDS phase input.
- Integrates a frequency tuning word (FTW) once per sample tick.
- Adds a static phase offset.
- Flags accumulator wrap.
- Accepts FTW updates through a valid/ready handshake, either immediately or synchronised to the next wrap (glitch-free frequency change).

Parameters:
ACC_W, 32, accumulator, FTW, offset and DDS output width.
PRESCALE, 1, clocks per sample tick (>=1); the prescale counter is $clog2(PRESCALE)+1 bits.

Ports:
CLK  in  1  system clock, all logic on rising edge.
RESET  in  1  synchronous, active-high reset.
RUN  in  1  level; 1 = prescaler and accumulator advance, 0 = hold.
FTW_IN  in  ACC_W  new tuning word.
FTW_SYNC  in  1  qualifies FTW_IN: 1 = apply at next wrap, 0 = apply immediately.
FTW_VALID  in  1  FTW_IN/FTW_SYNC valid.
FTW_READY  out  1  block can accept an FTW.
PHASE_OFS  in  ACC_W  phase offset, sampled every tick (quasi-static).
PHASE_CLR  in  1  single-cycle pulse; zero the phase.
DDS  out  ACC_W  registered phase word to the sine stage.
DDS_VALID  out  1  one-cycle pulse: DDS updated this cycle.
WRAP  out  1  one-cycle pulse, coincident with DDS_VALID: the accumulator carried out.

Behaviour:
- Reset (RESET=1 at an edge) clears everything:
  - acc, ftw_active, ftw_pend, prescale counter pc, DDS: all 0.
  - DDS_VALID, WRAP: 0.
  - state = IDLE, FTW_READY = 1.
- Priority at each edge: RESET > PHASE_CLR > tick.
- Prescaler:
  - pc advances only while RUN=1.
  - tick = RUN && (pc == PRESCALE-1).
  - On tick, pc <= 0; otherwise, while RUN=1, pc <= pc+1.
  - With PRESCALE=1, tick = RUN.
  - RUN=0 freezes pc and acc.
- Tick edge:
  - {carry, acc_n} = acc + ftw_active, computed in ACC_W+1 bits (modulo 2^ACC_W).
  - acc <= acc_n.
  - DDS <= acc_n + PHASE_OFS (mod 2^ACC_W).
  - DDS_VALID <= 1; WRAP <= carry.
  - Latency: DDS/DDS_VALID are visible the cycle after the tick condition.
- Non-tick edge: DDS holds; DDS_VALID <= 0; WRAP <= 0.
- WRAP follows the acc carry only; PHASE_OFS never produces WRAP.
- FSM states: IDLE (RUN=0, no pending FTW), RUN (RUN=1, no pending FTW), PEND (pending sync FTW, regardless of RUN).
  - IDLE <-> RUN follows the RUN level.
  - FTW_READY = (state != PEND).
  - Accept = FTW_VALID && FTW_READY.
  - Accept with FTW_SYNC=0: ftw_active <= FTW_IN; state unchanged.
  - Accept with FTW_SYNC=1: ftw_pend <= FTW_IN; state -> PEND.
  - In PEND, on the tick edge whose carry = 1: that increment uses the old ftw_active; then ftw_active <= ftw_pend; state -> RUN if RUN=1, else IDLE.
- Simultaneous events:
  - Accept and tick in the same cycle: the tick uses the old ftw_active; the new word is effective from the next tick.
  - PHASE_CLR and accept in the same cycle: both take effect.
- PHASE_CLR:
  - acc <= 0, pc <= 0.
  - DDS <= PHASE_OFS; DDS_VALID <= 0; WRAP <= 0.
  - ftw_active, ftw_pend and state are retained; a pending sync FTW still waits for the next carry.
  - A tick in the same cycle is discarded.
- Reset mid-PEND: the pending word is discarded and FTW_READY = 1 on the cycle after reset.
- FTW = 0: DDS stays constant (acc + offset) and DDS_VALID still pulses per tick.
- All-ones FTW: carry on every tick except when acc = 0.
- No other outputs are combinational from inputs except FTW_READY, which is combinational from state only.

Test Plan:
1. Reset, RUN=1, PRESCALE=1, immediate FTW=0x40000000 -> DDS = 0x40000000, 0x80000000, 0xC0000000, 0x00000000 on consecutive cycles; DDS_VALID continuously 1; WRAP=1 only with 0x00000000.
2. PRESCALE=4, FTW=0x10000000 -> DDS_VALID every 4th clock, DDS steps by 0x10000000; RUN=0 for 10 clocks -> no DDS_VALID, DDS/pc frozen, then resumes the same spacing.
3. Running at FTW=0x40000000 with acc=0x40000000, sync-load 0x20000000 -> FTW_READY=0 immediately. Outputs 0x80000000, 0xC0000000, 0x00000000 (WRAP=1), then 0x20000000, 0x40000000. FTW_READY=1 the cycle after the wrap tick. A second FTW_VALID held during PEND is not accepted until then.
4. PHASE_OFS=0x80000000, FTW=0x40000000 -> DDS = 0xC0000000, 0x00000000, 0x40000000, 0x80000000; WRAP=1 coincident with 0x80000000 (acc carry), not with 0x00000000.
5. PHASE_CLR pulse at acc=0x80000000 -> next DDS = PHASE_OFS with DDS_VALID=0, then increments from 0. RESET asserted during PEND -> all outputs 0, FTW_READY=1, and the pending word is never applied.
6. FTW=0xFFFFFFFF from reset -> DDS = 0xFFFFFFFF (WRAP=0), 0xFFFFFFFE (WRAP=1), 0xFFFFFFFD (WRAP=1), ...
